// File: rtl/spmm_out_collector_if.sv
// Handshake bundle between the SpMM PE array, the output collector and the drain consumer.
// Row capture enters on in_*; the completed matrix leaves as LANES-row groups on out_*.
interface spmm_out_collector_if #(
   parameter int N     = 16,
   parameter int W     = 8,
   parameter int LANES = 4
);
   logic                              in_valid;
   logic                              in_accum;
   logic [N-1:0][W-1:0]               in_row;
   logic                              in_ready;
   logic                              out_ready;
   logic                              out_start;
   logic                              out_valid;
   logic [LANES-1:0][N-1:0][W-1:0]    out_data;
   logic                              overflow;

   modport master (
      output in_valid, in_accum, in_row, out_start,
      input  in_ready, out_ready, out_valid, out_data, overflow
   );

   modport slave (
      input  in_valid, in_accum, in_row, out_start,
      output in_ready, out_ready, out_valid, out_data, overflow
   );
endinterface

// File: rtl/spmm_out_collector.sv
// Collects N PE result rows into an NxN buffer (optionally accumulating onto the
// previous contents), then streams the matrix out LANES rows per cycle.
module spmm_out_collector #(
   parameter int N     = 16,
   parameter int W     = 8,
   parameter int LANES = 4
) (
   input  logic                clock,
   input  logic                reset,
   spmm_out_collector_if.slave bus
);
   localparam int GROUPS = N / LANES;
   localparam int RW     = (N > 1) ? $clog2(N) : 1;
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;

   state_t              state, state_next;
   logic [RW-1:0]       row_ctr;
   logic [GW-1:0]       grp_ctr;
   logic [GW-1:0]       grp_idx;
   logic                acc_mode;
   logic                eff_acc;
   logic                row_write;
   logic                drain_load;
   logic                last_row;
   logic                last_grp;
   logic [N-1:0][W-1:0] new_row;
   logic [N-1:0][W-1:0] row_buf [N];

   // Row 0 picks up in_accum directly so the first row of a batch already uses the new mode.
   always_comb begin
      row_write  = (state == FILL) && bus.in_valid;
      eff_acc    = (row_ctr == '0) ? bus.in_accum : acc_mode;
      last_row   = (row_ctr == RW'(N - 1));
      drain_load = ((state == FULL) && bus.out_start) || (state == DRAIN);
      grp_idx    = (state == DRAIN) ? grp_ctr : '0;
      last_grp   = (grp_idx == GW'(GROUPS - 1));
      for (int j = 0; j < N; j++) begin
         new_row[j] = eff_acc ? (row_buf[row_ctr][j] + bus.in_row[j]) : bus.in_row[j];
      end
      state_next = state;
      case (state)
         FILL:    if (row_write && last_row) state_next = FULL;
         FULL:    if (bus.out_start) state_next = last_grp ? FILL : DRAIN;
         DRAIN:   if (last_grp) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   // The buffer is deliberately never cleared, so accumulate batches build on drained data.
   always_ff @(posedge clock) begin
      if (!reset && row_write) begin
         row_buf[row_ctr] <= new_row;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= FILL;
         row_ctr       <= '0;
         grp_ctr       <= '0;
         acc_mode      <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_ready <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.overflow  <= 1'b0;
      end else begin
         state         <= state_next;
         bus.in_ready  <= (state_next == FILL);
         bus.out_ready <= (state_next == FULL);
         if (row_write) begin
            row_ctr <= last_row ? '0 : row_ctr + 1'b1;
            if (row_ctr == '0) acc_mode <= bus.in_accum;
         end
         if (bus.in_valid && (state != FILL)) bus.overflow <= 1'b1;
         // Group 0 is loaded on the out_start cycle itself, later groups on each DRAIN cycle.
         if (drain_load) begin
            bus.out_valid <= 1'b1;
            grp_ctr       <= grp_idx + 1'b1;
            for (int k = 0; k < LANES; k++) begin
               bus.out_data[k] <= row_buf[RW'(int'(grp_idx) * LANES + k)];
            end
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_spmm_out_collector.sv
// Directed bench for spmm_out_collector: a reference buffer model feeds a queue of
// expected drain groups that is compared against the DUT output as groups appear.
module tb_spmm_out_collector;
   localparam int N      = 16;
   localparam int W      = 8;
   localparam int LANES  = 4;
   localparam int GROUPS = N / LANES;
   localparam int DW     = LANES * N * W;

   typedef logic [N-1:0][W-1:0]            row_t;
   typedef logic [LANES-1:0][N-1:0][W-1:0] grp_t;

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic [W-1:0] model [N][N];
   bit           accModel;
   grp_t         expQ [$];
   grp_t         lastGrp;

   always #5 clock = ~clock;

   spmm_out_collector_if #(.N(N), .W(W), .LANES(LANES)) bus ();

   spmm_out_collector #(.N(N), .W(W), .LANES(LANES)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic row_t rowData(input int kind, input int v, input int r);
      row_t d;
      for (int j = 0; j < N; j++) begin
         case (kind)
            0:       d[j] = W'(r * N + j);
            1:       d[j] = W'(v);
            default: d[j] = W'(r * 7 + j * 3 + v);
         endcase
      end
      return d;
   endfunction

   // Drives one 16-row batch; in_accum is inverted on rows 1..N-1 to show it only matters on row 0.
   task automatic applyStimulus(input int kind, input int v, input bit accum, input int gap,
                                input bit startOnLast);
      row_t d;
      for (int r = 0; r < N; r++) begin
         checkOutput("in_ready_fill", DW'(bus.in_ready), DW'(1));
         d             = rowData(kind, v, r);
         bus.in_valid  = 1'b1;
         bus.in_row    = d;
         bus.in_accum  = (r == 0) ? accum : !accum;
         bus.out_start = startOnLast && (r == N - 1);
         if (r == 0) accModel = accum;
         for (int j = 0; j < N; j++) begin
            model[r][j] = accModel ? W'(model[r][j] + d[j]) : d[j];
         end
         tick();
         bus.in_valid  = 1'b0;
         bus.in_accum  = 1'b0;
         bus.out_start = 1'b0;
         if (r < N - 1) repeat (gap) tick();
      end
      checkOutput("out_ready_rise", DW'(bus.out_ready), DW'(1));
      checkOutput("in_ready_drop", DW'(bus.in_ready), DW'(0));
   endtask

   task automatic drainAndCheck(input int delay, input bit garbage, input bit tail);
      grp_t e;
      repeat (delay) begin
         checkOutput("out_ready_hold", DW'(bus.out_ready), DW'(1));
         checkOutput("out_valid_idle", DW'(bus.out_valid), DW'(0));
         tick();
      end
      for (int g = 0; g < GROUPS; g++) begin
         for (int k = 0; k < LANES; k++)
            for (int j = 0; j < N; j++)
               e[k][j] = model[g * LANES + k][j];
         expQ.push_back(e);
      end
      bus.out_start = 1'b1;
      if (garbage) begin
         bus.in_valid = 1'b1;
         bus.in_row   = rowData(2, 99, 0);
      end
      for (int g = 0; g < GROUPS; g++) begin
         tick();
         bus.out_start = 1'b0;
         if (g == 0) checkOutput("out_ready_drop", DW'(bus.out_ready), DW'(0));
         checkOutput("out_valid_grp", DW'(bus.out_valid), DW'(1));
         if (expQ.size() > 0) e = expQ.pop_front();
         else e = 'x;
         checkOutput("out_data_grp", bus.out_data, e);
         lastGrp = e;
      end
      bus.in_valid = 1'b0;
      checkOutput("in_ready_return", DW'(bus.in_ready), DW'(1));
      checkOutput("out_ready_low", DW'(bus.out_ready), DW'(0));
      if (tail) begin
         tick();
         checkOutput("out_valid_fall", DW'(bus.out_valid), DW'(0));
         checkOutput("out_data_hold", bus.out_data, lastGrp);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_accum  = 1'b0;
      bus.in_row    = '0;
      bus.out_start = 1'b0;
      reset         = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rst_in_ready", DW'(bus.in_ready), DW'(1));
      checkOutput("rst_out_ready", DW'(bus.out_ready), DW'(0));
      checkOutput("rst_out_valid", DW'(bus.out_valid), DW'(0));
      checkOutput("rst_out_data", bus.out_data, DW'(0));
      checkOutput("rst_overflow", DW'(bus.overflow), DW'(0));

      $display("[TB] basic fill/drain");
      applyStimulus(0, 0, 1'b0, 0, 1'b0);
      drainAndCheck(3, 1'b0, 1'b1);

      $display("[TB] gapped input");
      applyStimulus(0, 0, 1'b0, 1, 1'b0);
      drainAndCheck(1, 1'b0, 1'b1);

      $display("[TB] accumulate");
      applyStimulus(1, 200, 1'b0, 0, 1'b0);
      drainAndCheck(0, 1'b0, 1'b1);
      applyStimulus(1, 100, 1'b1, 0, 1'b0);
      drainAndCheck(0, 1'b0, 1'b1);
      checkOutput("accum_wrap_44", DW'(bus.out_data[LANES-1][N-1]), DW'(44));
      applyStimulus(0, 0, 1'b0, 0, 1'b0);
      drainAndCheck(0, 1'b0, 1'b1);

      $display("[TB] protocol violations");
      bus.out_start = 1'b1;
      tick();
      tick();
      bus.out_start = 1'b0;
      checkOutput("fill_start_ignored", DW'(bus.out_valid), DW'(0));
      checkOutput("fill_in_ready", DW'(bus.in_ready), DW'(1));
      checkOutput("fill_no_overflow", DW'(bus.overflow), DW'(0));
      applyStimulus(2, 5, 1'b0, 0, 1'b1);
      tick();
      checkOutput("last_row_start_ignored", DW'(bus.out_valid), DW'(0));
      checkOutput("still_full", DW'(bus.out_ready), DW'(1));
      bus.in_valid = 1'b1;
      bus.in_row   = rowData(1, 77, 0);
      tick();
      bus.in_valid = 1'b0;
      checkOutput("overflow_full", DW'(bus.overflow), DW'(1));
      drainAndCheck(2, 1'b1, 1'b1);
      checkOutput("overflow_sticky", DW'(bus.overflow), DW'(1));

      $display("[TB] reset mid-drain");
      applyStimulus(2, 11, 1'b0, 0, 1'b0);
      bus.out_start = 1'b1;
      tick();
      bus.out_start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
      checkOutput("mid_rst_in_ready", DW'(bus.in_ready), DW'(1));
      checkOutput("mid_rst_out_ready", DW'(bus.out_ready), DW'(0));
      checkOutput("mid_rst_overflow", DW'(bus.overflow), DW'(0));
      applyStimulus(2, 23, 1'b0, 0, 1'b0);
      drainAndCheck(1, 1'b0, 1'b1);

      $display("[TB] back-to-back batches");
      applyStimulus(2, 40, 1'b0, 0, 1'b0);
      drainAndCheck(0, 1'b0, 1'b0);
      applyStimulus(1, 3, 1'b1, 0, 1'b0);
      drainAndCheck(0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spmm_out_collector.md
Name: spmm_out_collector

Overview:
- Downstream of the PE array inside SpMM.
- Each cycle, the N PEs together produce one output row (one element per PE). This block captures those rows into an N×N output buffer, with optional output-stationary accumulation.
- Once all N rows are held, it raises out_ready and streams the matrix out as LANES rows per cycle over N/LANES cycles.
- It replaces the ad-hoc out_buffer and out-start logic in SpMM with a single handshaked stage.

Parameters:
N, 16, matrix dimension; power of two, ≥ LANES
W, 8, data element width in bits
LANES, 4, rows emitted per drain cycle; divides N

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
in_valid  input  1  in_row carries the next output row
in_accum  input  1  output-stationary mode; sampled only with row 0
in_row  input  N×W  one result row; element j comes from PE j
in_ready  output  1  collector is in FILL and accepts rows
out_ready  output  1  full matrix is held and available for draining
out_start  input  1  begin draining
out_valid  output  1  out_data holds a valid row group
out_data  output  LANES×N×W  rows 4g..4g+3 of the buffer during drain step g (for LANES=4)
overflow  output  1  sticky: in_valid was seen while not in FILL

Behaviour:
- Reset values: state=FILL, row_ctr=0, grp_ctr=0, in_ready=1, out_ready=0, out_valid=0, out_data=all 0, overflow=0.
  - Buffer contents are not reset.
  - acc_mode=0.
- FSM states: FILL, FULL, DRAIN.
- FILL:
  - On in_valid, write row row_ctr at the clock edge, then increment row_ctr.
  - Row write rule: if acc_mode=1, buf[r][j] ← buf[r][j]+in_row[j], truncated mod 2^W; otherwise buf[r][j] ← in_row[j].
  - When row_ctr=0 and in_valid=1, acc_mode ← in_accum. That same row 0 already uses the new in_accum value, combinationally.
  - Rows need not arrive back-to-back; gaps in in_valid are allowed.
  - When row N-1 is written: row_ctr wraps to 0 and state → FULL.
  - in_ready=1 only in FILL, registered: it drops the cycle after row N-1 is written.
- FULL:
  - out_ready=1, registered: it rises the cycle after the last row write.
  - in_valid in FULL sets overflow; the row is discarded.
  - out_start=1 → DRAIN; grp_ctr=0; out_ready drops the next cycle.
- DRAIN:
  - On each cycle in DRAIN, including the cycle out_start is accepted: out_data[k] ← buf[grp_ctr*LANES+k], out_valid ← 1, grp_ctr increments.
  - Consequence: group g is visible exactly 1+g cycles after the out_start cycle, for N/LANES consecutive cycles.
  - After group N/LANES-1 is loaded: state → FILL, in_ready=1 on the next cycle.
  - out_valid falls one cycle after the last group was shown; out_data holds its last value.
  - in_valid in DRAIN sets overflow; the row is discarded.
- out_start outside FULL is ignored; there is no error.
- Draining does not clear the buffer, so the next accumulate batch adds to the drained values.
- Simultaneous events:
  - in_valid on row N-1 and out_start in the same cycle: out_start is ignored because the state is still FILL.
- overflow clears only on reset.
- Reset mid-FILL or mid-DRAIN:
  - Returns to FILL immediately; partial rows remain in the buffer but are overwritten unless the next batch has in_accum=1.
  - out_valid=0 on the cycle after reset.
- Arithmetic: W-bit wraparound add; no saturation.

Test Plan:
- Basic fill/drain (N=16):
  - Stimulus: rows r with in_row[j]=r*16+j mod 256, back-to-back, in_accum=0; out_start 3 cycles after out_ready rises.
  - Required: out_ready 1 cycle after row 15; groups g=0..3 on consecutive cycles; out_data[k][j]=(4g+k)*16+j mod 256.
- Gapped input:
  - Stimulus: in_valid on alternate cycles.
  - Required: identical buffer contents; out_ready 1 cycle after the 16th valid.
- Accumulate:
  - Stimulus: batch 1 all elements 200, drained; batch 2 all elements 100 with in_accum=1 on row 0.
  - Required: every drained element is 44 ((200+100) mod 256); in_accum=0 on row 0 of batch 3 → plain overwrite.
- Protocol violations:
  - Stimulus: out_start during FILL; then in_valid during FULL and DRAIN.
  - Required: no drain starts; overflow=1 and stays 1; buffer contents are unchanged.
- Reset mid-drain:
  - Stimulus: assert reset at drain step 2.
  - Required: next cycle out_valid=0, in_ready=1, out_ready=0; a fresh 16-row batch drains correctly.
- Back-to-back batches:
  - Stimulus: start the new batch's rows on the first cycle in_ready returns high.
  - Required: no row lost; second matrix drains correctly.
